// File: rtl/hex_pkg.sv
// hex_pkg: shared seven-segment types and the active-low hex glyph table.
package hex_pkg;
   typedef logic [6:0] seg7_t;
   localparam seg7_t SEG_OFF = 7'b1111111;
   localparam seg7_t SEG_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to active-low segment pattern.
module seg7_decode
   import hex_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg7_t      seg_o
);
   assign seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: latched multi-digit hex display with load/shift, enables, leading-zero suppression.
// Define HEX_BLINK_EN to build the per-digit blink engine; otherwise blink_mask is ignored.
module hex_display_ctrl
   import hex_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    shift,
   input  logic [3:0]              nibble,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [7*NUM_DIGITS-1:0] hex_out
);
   localparam int DW = 4 * NUM_DIGITS;
   logic [DW-1:0]           disp_q, disp_d;
   logic [DW+3:0]           shifted;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [NUM_DIGITS:0]     zero_above;
   logic                    blink_phase;
   // Appending the nibble below the register keeps the slice legal for a single digit.
   assign shifted = {disp_q, nibble};
   assign disp_d  = load ? value : shift ? shifted[DW-1:0] : disp_q;
   always_ff @(posedge clk) begin
      disp_q <= reset ? '0 : disp_d;
      hex_q  <= reset ? '1 : hex_d;
   end
`ifdef HEX_BLINK_EN
   localparam int CW = $clog2(BLINK_DIV);
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic          wrap;
   assign wrap          = blink_cnt_q == CW'(BLINK_DIV - 1);
   assign blink_cnt_d   = wrap ? '0 : blink_cnt_q + 1'b1;
   assign blink_phase_d = blink_phase_q ^ wrap;
   always_ff @(posedge clk) begin
      blink_cnt_q   <= reset ? '0 : blink_cnt_d;
      blink_phase_q <= reset ? 1'b0 : blink_phase_d;
   end
   assign blink_phase = blink_phase_q;
`else
   assign blink_phase = 1'b0;
`endif
   assign zero_above[NUM_DIGITS] = 1'b1;
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      seg7_t seg;
      logic  lz_off;
      seg7_decode u_dec (.nib_i(disp_q[4*g+:4]), .seg_o(seg));
      assign zero_above[g] = zero_above[g+1] & (disp_q[4*g+:4] == 4'h0);
      assign lz_off = blank_lz & zero_above[g] & (g != 0);
      assign hex_d[7*g+:7] = (!digit_en[g] || lz_off || (blink_phase && blink_mask[g])) ? SEG_OFF : seg;
   end
   assign hex_out = hex_q;
endmodule
